// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared FSM states, error codes and timing helpers for the DHT reader
package dht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_LOW = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RESP_LOW  = 3'd3,
        ST_RESP_HIGH = 3'd4,
        ST_BIT_LOW   = 3'd5,
        ST_BIT_HIGH  = 3'd6,
        ST_CHECK     = 3'd7
    } dht_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_RESP  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    localparam int unsigned FRAME_BITS = 40;

    // Rounds up so a threshold is never shorter than the requested time.
    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned clk_hz);
        return (us * clk_hz + 64'd999_999) / 64'd1_000_000;
    endfunction

    function automatic longint unsigned max_u64(input longint unsigned a,
                                                input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dht_line_sync.sv
// rtl/dht_line_sync.sv - two-flop synchroniser for the sensor line with rise/fall pulses
module dht_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset high to match the idle pulled-up line, so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/dht_sensor_reader.sv
// rtl/dht_sensor_reader.sv - DHT11/DHT22 single-wire reader with retries, timeouts and decode
module dht_sensor_reader
    import dht_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 125_000_000,
    parameter int unsigned SENSOR_TYPE    = 0,
    parameter int unsigned START_LOW_US   = 18000,
    parameter int unsigned BIT_THRESH_US  = 40,
    parameter int unsigned TIMEOUT_US     = 200,
    parameter int unsigned HOLDOFF_MS     = 1000,
    parameter int unsigned AUTO_PERIOD_MS = 0,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         dht_io,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic [39:0] raw,
    output logic [2:0]  state
);

    localparam longint unsigned START_C   = us_to_cycles(64'(START_LOW_US), 64'(CLK_HZ));
    localparam longint unsigned THRESH_C  = us_to_cycles(64'(BIT_THRESH_US), 64'(CLK_HZ));
    localparam longint unsigned TIMEOUT_C = us_to_cycles(64'(TIMEOUT_US), 64'(CLK_HZ));
    localparam longint unsigned HOLD_C    = us_to_cycles(64'(HOLDOFF_MS) * 64'd1000, 64'(CLK_HZ));
    localparam longint unsigned AUTO_RAW  = us_to_cycles(64'(AUTO_PERIOD_MS) * 64'd1000, 64'(CLK_HZ));
    localparam longint unsigned AUTO_C    = max_u64(max_u64(AUTO_RAW, HOLD_C), 64'd1);
    localparam longint unsigned MAX_C     =
        max_u64(max_u64(START_C, TIMEOUT_C), max_u64(HOLD_C, AUTO_C));

    localparam int TW = $clog2(MAX_C + 2);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    localparam logic [TW-1:0] START_T   = TW'(START_C);
    localparam logic [TW-1:0] THRESH_T  = TW'(THRESH_C);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_C);
    localparam logic [TW-1:0] HOLD_T    = TW'(HOLD_C);
    localparam logic [TW-1:0] AUTO_T    = TW'(AUTO_C);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [5:0]    LAST_BIT  = 6'(FRAME_BITS - 1);

    dht_state_t      fsm;
    logic            drive_low;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   holdoff;
    logic [TW-1:0]   auto_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [5:0]      bit_cnt;
    logic [39:0]     shift;
    logic            pending;

    logic            rise;
    logic            fall;
    logic            holdoff_done;
    logic            auto_tick;
    logic            timed_out;
    logic            fail;
    logic [1:0]      fail_code;
    logic [7:0]      sum8;
    logic            sum_ok;
    logic [15:0]     mag;
    logic [15:0]     temp_dec;

    // The host only ever pulls low; the external pull-up provides the high level.
    assign dht_io = drive_low ? 1'b0 : 1'bz;
    assign state  = fsm;

    dht_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .line (dht_io),
        .rise (rise),
        .fall (fall)
    );

    assign holdoff_done = (holdoff >= HOLD_T);
    assign auto_tick    = (AUTO_PERIOD_MS != 0) && (auto_cnt >= AUTO_T - 1'b1);
    assign timed_out    = (timer >= TIMEOUT_T);

    always_comb begin
        sum8     = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];
        sum_ok   = (sum8 == shift[7:0]);
        mag      = {1'b0, shift[22:16], shift[15:8]};
        temp_dec = shift[23:8];
        if (SENSOR_TYPE == 1) begin
            temp_dec = shift[23] ? (16'd0 - mag) : mag;
        end
    end

    // A phase fails only when its timer expired without the awaited edge, so an edge wins a tie.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (fsm)
            ST_RELEASE, ST_RESP_HIGH: begin
                if (!fall && timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_RESP;
                end
            end
            ST_RESP_LOW: begin
                if (!rise && timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_RESP;
                end
            end
            ST_BIT_LOW: begin
                if (!rise && timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_BIT_HIGH: begin
                if (!fall && timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (!sum_ok) begin
                    fail      = 1'b1;
                    fail_code = ERR_CHECKSUM;
                end
            end
            default: begin
                fail      = 1'b0;
                fail_code = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm         <= ST_IDLE;
            drive_low   <= 1'b0;
            timer       <= '0;
            holdoff     <= '0;
            auto_cnt    <= '0;
            retry_cnt   <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            pending     <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            humidity    <= '0;
            temperature <= '0;
            raw         <= '0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            timer <= timer + 1'b1;

            if (fsm == ST_IDLE && !holdoff_done) begin
                holdoff <= holdoff + 1'b1;
            end
            if (auto_tick) begin
                auto_cnt <= '0;
            end else begin
                auto_cnt <= auto_cnt + 1'b1;
            end

            if (!busy && (start || auto_tick)) begin
                pending <= 1'b1;
                busy    <= 1'b1;
            end

            if (fail) begin
                fsm     <= ST_IDLE;
                timer   <= '0;
                holdoff <= '0;
                if (retry_cnt == RETRY_MAX) begin
                    error     <= 1'b1;
                    err_code  <= fail_code;
                    busy      <= 1'b0;
                    pending   <= 1'b0;
                    retry_cnt <= '0;
                end else begin
                    // pending stays set so the retry launches itself after the holdoff
                    retry_cnt <= retry_cnt + 1'b1;
                end
            end else begin
                case (fsm)
                    ST_IDLE: begin
                        timer <= '0;
                        if (pending && holdoff_done) begin
                            fsm       <= ST_START_LOW;
                            drive_low <= 1'b1;
                            bit_cnt   <= '0;
                            shift     <= '0;
                        end
                    end
                    ST_START_LOW: begin
                        if (timer >= START_T - 1'b1) begin
                            fsm       <= ST_RELEASE;
                            drive_low <= 1'b0;
                            timer     <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (fall) begin
                            fsm   <= ST_RESP_LOW;
                            timer <= '0;
                        end
                    end
                    ST_RESP_LOW: begin
                        if (rise) begin
                            fsm   <= ST_RESP_HIGH;
                            timer <= '0;
                        end
                    end
                    ST_RESP_HIGH: begin
                        if (fall) begin
                            fsm   <= ST_BIT_LOW;
                            timer <= '0;
                        end
                    end
                    ST_BIT_LOW: begin
                        if (rise) begin
                            fsm   <= ST_BIT_HIGH;
                            timer <= '0;
                        end
                    end
                    ST_BIT_HIGH: begin
                        // timer reads high width minus one at the falling edge
                        if (fall) begin
                            shift   <= {shift[38:0], (timer >= THRESH_T)};
                            bit_cnt <= bit_cnt + 1'b1;
                            timer   <= '0;
                            fsm     <= (bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
                        end
                    end
                    ST_CHECK: begin
                        fsm         <= ST_IDLE;
                        timer       <= '0;
                        holdoff     <= '0;
                        valid       <= 1'b1;
                        busy        <= 1'b0;
                        pending     <= 1'b0;
                        retry_cnt   <= '0;
                        err_code    <= ERR_NONE;
                        raw         <= shift;
                        humidity    <= shift[39:24];
                        temperature <= temp_dec;
                    end
                    default: begin
                        fsm       <= ST_IDLE;
                        drive_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dht_sensor_reader.sv
// tb/tb_dht_sensor_reader.sv - scoreboard bench for dht_sensor_reader with DHT11 and DHT22 line models
module tb_dht_sensor_reader;

    localparam int M_OK     = 0;
    localparam int M_SILENT = 1;
    localparam int M_STALL  = 2;

    typedef struct {
        bit         inst;
        bit         is_err;
        logic [1:0] code;
        logic [15:0] hum;
        logic [15:0] tmp;
        logic [39:0] raw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst;
    logic start_a;
    logic start_b;
    logic [1:0] mlow;

    wire io_a;
    wire io_b;
    assign io_a = mlow[0] ? 1'b0 : 1'bz;
    assign io_b = mlow[1] ? 1'b0 : 1'bz;
    pullup (io_a);
    pullup (io_b);

    logic        busy_a, valid_a, error_a, busy_b, valid_b, error_b;
    logic [1:0]  code_a, code_b;
    logic [15:0] hum_a, tmp_a, hum_b, tmp_b;
    logic [39:0] raw_a, raw_b;
    logic [2:0]  state_a, state_b;

    always #5 clk = ~clk;

    dht_sensor_reader #(
        .CLK_HZ(1_000_000), .SENSOR_TYPE(0), .START_LOW_US(500), .HOLDOFF_MS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .dht_io(io_a), .start(start_a), .busy(busy_a),
        .valid(valid_a), .error(error_a), .err_code(code_a), .humidity(hum_a),
        .temperature(tmp_a), .raw(raw_a), .state(state_a)
    );

    dht_sensor_reader #(
        .CLK_HZ(1_000_000), .SENSOR_TYPE(1), .START_LOW_US(1000), .HOLDOFF_MS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .dht_io(io_b), .start(start_b), .busy(busy_b),
        .valid(valid_b), .error(error_b), .err_code(code_b), .humidity(hum_b),
        .temperature(tmp_b), .raw(raw_b), .state(state_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input bit sel, input bit is_err, input logic [1:0] code,
                        input logic [15:0] h, input logic [15:0] t, input logic [39:0] r);
        exp_q.push_back('{sel, is_err, code, h, t, r});
    endtask

    task automatic score(input bit sel, input bit is_err, input logic [1:0] code, input logic b,
                         input logic [15:0] h, input logic [15:0] t, input logic [39:0] r);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe inst=%0d actual=strobe required=none", sel);
            return;
        end
        e = exp_q.pop_front();
        check("strobe_inst", 64'(sel), 64'(e.inst));
        check("strobe_kind", 64'(is_err), 64'(e.is_err));
        check("err_code", 64'(code), 64'(e.code));
        check("busy_at_strobe", 64'(b), 64'd0);
        check("humidity", 64'(h), 64'(e.hum));
        check("temperature", 64'(t), 64'(e.tmp));
        check("raw", 64'(r), 64'(e.raw));
    endtask

    always @(negedge clk) begin
        if (valid_a || error_a) score(1'b0, error_a, code_a, busy_a, hum_a, tmp_a, raw_a);
        if (valid_b || error_b) score(1'b1, error_b, code_b, busy_b, hum_b, tmp_b, raw_b);
    end

    function automatic logic line(input bit sel);
        return sel ? io_b : io_a;
    endfunction

    task automatic hold(input bit sel, input logic lvl, input int n);
        mlow[sel] = ~lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_line(input bit sel, input logic lvl, input int budget,
                             input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (line(sel) == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=timeout required=line_%0d", name, lvl);
        end
    endtask

    // One sensor transaction: wait for the host start pulse, then answer per mode.
    task automatic respond(input bit sel, input logic [39:0] frame, input int mode);
        bit ok;
        wait_line(sel, 1'b0, 6000, "start_low_seen", ok);
        if (!ok) return;
        wait_line(sel, 1'b1, 3000, "start_released", ok);
        if (!ok || mode == M_SILENT) return;
        hold(sel, 1'b1, 30);
        hold(sel, 1'b0, 80);
        hold(sel, 1'b1, 80);
        for (int b = 0; b < 40; b++) begin
            hold(sel, 1'b0, 50);
            if (mode == M_STALL && b == 17) begin
                hold(sel, 1'b1, 300);
                return;
            end
            hold(sel, 1'b1, frame[39-b] ? 70 : 26);
        end
        hold(sel, 1'b0, 50);
        hold(sel, 1'b1, 1);
    endtask

    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL strobe_wait actual=missing%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mlow    = 2'b00;
        repeat (5) @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_error", 64'(error_a), 64'd0);
        check("rst_code", 64'(code_a), 64'd0);
        check("rst_hum", 64'(hum_a), 64'd0);
        check("rst_tmp", 64'(tmp_a), 64'd0);
        check("rst_raw", 64'(raw_a), 64'd0);
        check("rst_state", 64'(state_a), 64'd0);
        check("rst_line", 64'(io_a), 64'd1);
        rst = 1'b1;

        // DHT11 good frame
        push(1'b0, 1'b0, 2'd0, 16'h3700, 16'h1900, 40'h37_00_19_00_50);
        pulse(1'b0);
        respond(1'b0, 40'h37_00_19_00_50, M_OK);
        drain(5000);

        // DHT22 negative temperature: 652 = 65.2 %RH, -101 = -10.1 C
        push(1'b1, 1'b0, 2'd0, 16'd652, 16'hFF9B, 40'h02_8C_80_65_73);
        pulse(1'b1);
        respond(1'b1, 40'h02_8C_80_65_73, M_OK);
        drain(5000);

        // bad checksum on all three attempts, outputs keep the last good frame
        push(1'b0, 1'b1, 2'd3, 16'h3700, 16'h1900, 40'h37_00_19_00_50);
        pulse(1'b0);
        for (int a = 0; a < 3; a++) respond(1'b0, 40'h37_00_19_00_51, M_OK);
        drain(5000);

        // silent sensor
        push(1'b0, 1'b1, 2'd1, 16'h3700, 16'h1900, 40'h37_00_19_00_50);
        pulse(1'b0);
        for (int a = 0; a < 3; a++) respond(1'b0, 40'h0, M_SILENT);
        drain(5000);

        // stall at bit 17, plus a start while busy that must be dropped
        push(1'b0, 1'b1, 2'd2, 16'h3700, 16'h1900, 40'h37_00_19_00_50);
        pulse(1'b0);
        respond(1'b0, 40'h37_00_19_00_50, M_STALL);
        pulse(1'b0);
        respond(1'b0, 40'h37_00_19_00_50, M_STALL);
        respond(1'b0, 40'h37_00_19_00_50, M_STALL);
        drain(5000);
        repeat (2500) @(negedge clk);
        check("busy_start_ignored", 64'(busy_a), 64'd0);
        check("idle_after_ignored", 64'(state_a), 64'd0);

        // reset during the host start pulse
        begin
            bit ok;
            pulse(1'b0);
            wait_line(1'b0, 1'b0, 6000, "rst_test_start_low", ok);
            repeat (10) @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check("rst_mid_line", 64'(io_a), 64'd1);
            check("rst_mid_state", 64'(state_a), 64'd0);
            check("rst_mid_valid", 64'(valid_a), 64'd0);
            check("rst_mid_error", 64'(error_a), 64'd0);
            check("rst_mid_busy", 64'(busy_a), 64'd0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (2500) @(negedge clk);
            check("post_rst_busy", 64'(busy_a), 64'd0);
            check("post_rst_line", 64'(io_a), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
